// File: rtl/data_mem_access_unit_pkg.sv
// Shared encodings for the data memory access unit: load/store funct3 codes,
// FSM state codes and the store lane helpers used by the request path.
package data_mem_access_unit_pkg;

  // Load funct3 codes (mem_read[2:0])
  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b100;
  localparam logic [2:0] MEM_LHU = 3'b101;

  // Store funct3[1:0] codes (mem_write[1:0])
  localparam logic [1:0] MEM_SB = 2'b00;
  localparam logic [1:0] MEM_SH = 2'b01;
  localparam logic [1:0] MEM_SW = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  function automatic logic is_valid_load(input logic [3:0] mem_read);
    logic ok;
    ok = 1'b0;
    if (mem_read[3]) begin
      case (mem_read[2:0])
        MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: ok = 1'b1;
        default:                                  ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic is_valid_store(input logic [2:0] mem_write);
    return mem_write[2] && (mem_write[1:0] != 2'b11);
  endfunction

  // size_code is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic is_misaligned(input logic [1:0] size_code,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size_code)
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_byteen(input logic [1:0] size_code,
                                              input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size_code)
      MEM_SB:  be = 4'b0001 << addr_lo;
      MEM_SH:  be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store data across lanes so byteen alone selects the target
  function automatic logic [31:0] store_wdata(input logic [1:0]  size_code,
                                              input logic [31:0] data);
    logic [31:0] wd;
    case (size_code)
      MEM_SB:  wd = {4{data[7:0]}};
      MEM_SH:  wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/data_mem_access_unit_load_data_extender.sv
// Load data extender: picks the addressed byte/halfword out of a memory word
// and sign- or zero-extends it according to the load funct3.
module load_data_extender
  import data_mem_access_unit_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select for sub-word loads
  always_comb begin
    w_byte = i_word[7:0];
    unique case (i_addr_lo)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  end

  // Extension by funct3
  always_comb begin
    o_result = 32'h0;
    case (i_funct3)
      MEM_LB:  o_result = {{24{w_byte[7]}}, w_byte};
      MEM_LH:  o_result = {{16{w_half[15]}}, w_half};
      MEM_LW:  o_result = i_word;
      MEM_LBU: o_result = {24'h0, w_byte};
      MEM_LHU: o_result = {16'h0, w_half};
      default: o_result = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// MEM-stage data memory access unit. Turns byte/half/word loads and stores into
// word-wide memory requests with byte enables, extends load data, and stalls
// the pipeline via busy_wait until the memory answers.
// Optional: define MISALIGN_CHECK_EN to reject misaligned half/word accesses
// without touching memory and flag them on misaligned_err.
module data_mem_access_unit
  import data_mem_access_unit_pkg::*;
#(
  parameter int unsigned MEM_ADDR_W = 30
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            mem_read,
  input  logic [2:0]            mem_write,
  input  logic [31:0]           address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  busy_wait,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_read_req,
  output logic                  mem_write_req,
  output logic [3:0]            mem_byteen,
  output logic [31:0]           mem_wdata,
`ifdef MISALIGN_CHECK_EN
  output logic                  misaligned_err,
`endif
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready
);

  state_e                r_state;
  state_e                w_state_next;
  logic                  r_is_store;
  logic [2:0]            r_funct3;
  logic [1:0]            r_addr_lo;
  logic [MEM_ADDR_W-1:0] r_mem_addr;
  logic [3:0]            r_byteen;
  logic [31:0]           r_wdata;
  logic [31:0]           r_read_data;

  logic                  w_load_valid;
  logic                  w_store_valid;
  logic                  w_req_valid;
  logic [1:0]            w_size_code;
  logic                  w_misaligned;
  logic                  w_start;
  logic [31:0]           w_ext;

  // Request decode; a store takes priority over a simultaneous load
  always_comb begin
    w_store_valid = is_valid_store(mem_write);
    w_load_valid  = is_valid_load(mem_read);
    w_req_valid   = w_store_valid || w_load_valid;
    w_size_code   = w_store_valid ? mem_write[1:0] : mem_read[1:0];
    w_start       = (r_state == ST_IDLE) && w_req_valid;
  end

`ifdef MISALIGN_CHECK_EN
  assign w_misaligned = is_misaligned(w_size_code, address[1:0]);
`else
  assign w_misaligned = 1'b0;
`endif

  // Next state, stall and strobes; DONE always returns to IDLE so the held
  // request of the completed access cannot retrigger
  always_comb begin
    w_state_next  = r_state;
    busy_wait     = 1'b0;
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req_valid) begin
          busy_wait    = 1'b1;
          w_state_next = w_misaligned ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        busy_wait     = 1'b1;
        mem_read_req  = !r_is_store;
        mem_write_req = r_is_store;
        if (mem_ready) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  load_data_extender u_extender (
    .i_word    (mem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_result  (w_ext)
  );

  // State register, request capture and load result capture
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_is_store  <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_mem_addr  <= '0;
      r_byteen    <= 4'b0000;
      r_wdata     <= 32'h0;
      r_read_data <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (w_start && !w_misaligned) begin
        r_is_store <= w_store_valid;
        r_funct3   <= w_store_valid ? {1'b0, mem_write[1:0]} : mem_read[2:0];
        r_addr_lo  <= address[1:0];
        r_mem_addr <= address[MEM_ADDR_W+1:2];
        if (w_store_valid) begin
          r_byteen <= store_byteen(mem_write[1:0], address[1:0]);
          r_wdata  <= store_wdata(mem_write[1:0], write_data);
        end else begin
          r_byteen <= 4'b0000;
        end
      end
      if ((r_state == ST_ACCESS) && mem_ready && !r_is_store) begin
        r_read_data <= w_ext;
      end
      if (w_start && w_misaligned && !w_store_valid) begin
        r_read_data <= 32'h0;
      end
    end
  end

`ifdef MISALIGN_CHECK_EN
  logic r_misaligned_err;

  // Error flag lives for exactly the DONE cycle of a rejected access
  always_ff @(posedge clock) begin
    if (reset) begin
      r_misaligned_err <= 1'b0;
    end else begin
      r_misaligned_err <= w_start && w_misaligned;
    end
  end

  assign misaligned_err = r_misaligned_err;
`endif

  assign read_data  = r_read_data;
  assign mem_addr   = r_mem_addr;
  assign mem_byteen = r_byteen;
  assign mem_wdata  = r_wdata;

endmodule
